agc_io_channels: RTL and testbench

- Peripheral I/O channel block for the AGC core.
- Provides eight 15-bit I/O channels addressed by 3-bit selects, with one combinational read port and one synchronous write port toward the Core.
- Channel roles: scratch registers, a free-running 30-bit scaler, two output latches driven to pins, and one synchronized input port.
- Sits beside the Core and agc_ram in the top level.

---
 rtl/agc_io_pkg.sv | 18 +
 rtl/agc_io_channels_if.sv | 23 ++
 rtl/agc_io_scaler.sv | 38 +++
 rtl/agc_io_channels.sv | 87 ++++++++
 tb/tb_agc_io_channels.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/agc_io_pkg.sv
// Shared types and channel numbering for the AGC peripheral I/O channels.
package agc_io_pkg;

  localparam int AGC_W    = 15;
  localparam int SCALER_W = 2 * AGC_W;

  typedef logic [AGC_W-1:0] agc_word_t;

  localparam logic [2:0] CH_ZERO     = 3'd0;
  localparam logic [2:0] CH_SCR1     = 3'd1;
  localparam logic [2:0] CH_SCR2     = 3'd2;
  localparam logic [2:0] CH_HISCALER = 3'd3;
  localparam logic [2:0] CH_LOSCALER = 3'd4;
  localparam logic [2:0] CH_OUT5     = 3'd5;
  localparam logic [2:0] CH_OUT6     = 3'd6;
  localparam logic [2:0] CH_IN7      = 3'd7;

endpackage

// File: rtl/agc_io_channels_if.sv
// Core-facing channel bus: combinational read port plus synchronous write port.
interface agc_io_channels_if;
  import agc_io_pkg::*;

  logic [2:0] IO_read_sel;
  agc_word_t  IO_read_data;
  logic [2:0] IO_write_sel;
  agc_word_t  IO_write_data;
  logic       IO_write_en;

  // Core side
  modport master (
    output IO_read_sel, IO_write_sel, IO_write_data, IO_write_en,
    input  IO_read_data
  );

  // Channel block side
  modport slave (
    input  IO_read_sel, IO_write_sel, IO_write_data, IO_write_en,
    output IO_read_data
  );

endinterface

// File: rtl/agc_io_scaler.sv
// Free-running 30-bit scaler advanced once every PRESCALE clocks.
// The two halves are exported independently; software re-reads the high
// half to detect a carry between the two reads.
module agc_io_scaler
  import agc_io_pkg::*;
#(
  parameter int PRESCALE = 1   // clocks per increment, must be >= 1
) (
  input  logic      clock,
  input  logic      reset_n,
  output agc_word_t scaler_hi,
  output agc_word_t scaler_lo
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]       pre;
  logic [SCALER_W-1:0] count;
  logic                pre_wrap;

  assign pre_wrap = (pre == PW'(PRESCALE - 1));

  // Prescaler runs 0..PRESCALE-1; the counter steps on its wrap and
  // rolls over from all-ones to zero on its own.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre   <= '0;
      count <= '0;
    end else begin
      pre <= pre_wrap ? '0 : pre + PW'(1);
      if (pre_wrap) count <= count + SCALER_W'(1);
    end
  end

  assign scaler_hi = count[SCALER_W-1:AGC_W];
  assign scaler_lo = count[AGC_W-1:0];

endmodule

// File: rtl/agc_io_channels.sv
// Eight 15-bit AGC I/O channels: zero, two scratch registers, scaler halves,
// two output latches driven to pins and a synchronized input port.
module agc_io_channels
  import agc_io_pkg::*;
#(
  parameter int DATA_W          = 15,  // tied to the AGC word
  parameter int SCALER_PRESCALE = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  agc_io_channels_if.slave  io,
  input  logic [DATA_W-1:0] chan_in,
  output logic [DATA_W-1:0] chan5_out,
  output logic [DATA_W-1:0] chan6_out,
  output logic [7:0]        chan_wr_pulse
);

  agc_word_t scr1, scr2, out5, out6;
  agc_word_t scaler_hi, scaler_lo;
  logic [1:0][DATA_W-1:0] in_pipe;   // [1] is the synchronized value

  agc_io_scaler #(.PRESCALE(SCALER_PRESCALE)) u_scaler (
    .clock     (clock),
    .reset_n   (reset_n),
    .scaler_hi (scaler_hi),
    .scaler_lo (scaler_lo)
  );

  // Writable channels; writes to read-only channels fall through untouched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scr1 <= '0;
      scr2 <= '0;
      out5 <= '0;
      out6 <= '0;
    end else if (io.IO_write_en) begin
      case (io.IO_write_sel)
        CH_SCR1: scr1 <= io.IO_write_data;
        CH_SCR2: scr2 <= io.IO_write_data;
        CH_OUT5: out5 <= io.IO_write_data;
        CH_OUT6: out6 <= io.IO_write_data;
        default: ;
      endcase
    end
  end

  // Strobe for every accepted write, ignored channels included, so dummy
  // writes can serve as software strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chan_wr_pulse <= '0;
    end else begin
      chan_wr_pulse <= '0;
      if (io.IO_write_en) chan_wr_pulse[io.IO_write_sel] <= 1'b1;
    end
  end

  // Two-flop synchronizer for the asynchronous input word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_pipe <= '0;
    end else begin
      in_pipe[0] <= chan_in;
      in_pipe[1] <= in_pipe[0];
    end
  end

  // Zero-latency read mux of current state; every select is decoded.
  always_comb begin
    io.IO_read_data = '0;
    case (io.IO_read_sel)
      CH_ZERO:     io.IO_read_data = '0;
      CH_SCR1:     io.IO_read_data = scr1;
      CH_SCR2:     io.IO_read_data = scr2;
      CH_HISCALER: io.IO_read_data = scaler_hi;
      CH_LOSCALER: io.IO_read_data = scaler_lo;
      CH_OUT5:     io.IO_read_data = out5;
      CH_OUT6:     io.IO_read_data = out6;
      CH_IN7:      io.IO_read_data = in_pipe[1];
      default:     io.IO_read_data = '0;
    endcase
  end

  assign chan5_out = out5;
  assign chan6_out = out6;

endmodule

// File: tb/tb_agc_io_channels.sv
// Randomized bench for agc_io_channels: two instances (prescale 1 and 4)
// share one stimulus stream and are checked against a channel-level model.
module tb_agc_io_channels;
  import agc_io_pkg::*;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  agc_word_t  chan_in = '0;
  logic [2:0] rsel = '0, wsel = '0;
  agc_word_t  wdata = '0;
  logic       wen = 1'b0;

  agc_word_t  c5_1, c6_1, c5_4, c6_4;
  logic [7:0] p_1, p_4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  agc_io_channels_if bus1();
  agc_io_channels_if bus4();

  assign bus1.IO_read_sel   = rsel;
  assign bus1.IO_write_sel  = wsel;
  assign bus1.IO_write_data = wdata;
  assign bus1.IO_write_en   = wen;
  assign bus4.IO_read_sel   = rsel;
  assign bus4.IO_write_sel  = wsel;
  assign bus4.IO_write_data = wdata;
  assign bus4.IO_write_en   = wen;

  agc_io_channels #(.DATA_W(15), .SCALER_PRESCALE(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .io(bus1), .chan_in(chan_in),
    .chan5_out(c5_1), .chan6_out(c6_1), .chan_wr_pulse(p_1)
  );

  agc_io_channels #(.DATA_W(15), .SCALER_PRESCALE(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .io(bus4), .chan_in(chan_in),
    .chan5_out(c5_4), .chan6_out(c6_4), .chan_wr_pulse(p_4)
  );

  // Reference model: channel contents, edges since reset release, the
  // input word as seen two edges back, and last edge's write strobe.
  agc_word_t   m_reg [8];
  int unsigned m_edges;
  agc_word_t   m_in_d1, m_in_d2;
  logic [7:0]  m_pulse;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) m_reg[i] <= '0;
      m_edges <= 0;
      m_in_d1 <= '0;
      m_in_d2 <= '0;
      m_pulse <= '0;
    end else begin
      m_edges <= m_edges + 1;
      m_in_d1 <= chan_in;
      m_in_d2 <= m_in_d1;
      m_pulse <= wen ? (8'b1 << wsel) : 8'b0;
      if (wen && (wsel inside {3'd1, 3'd2, 3'd5, 3'd6})) m_reg[wsel] <= wdata;
    end
  end

  function automatic agc_word_t exp_rd(input logic [2:0] sel, input int unsigned p);
    longint unsigned sc;
    sc = (longint'(m_edges) / p) % (64'd1 << 30);
    case (sel)
      3'd3:    exp_rd = agc_word_t'(sc >> 15);
      3'd4:    exp_rd = agc_word_t'(sc & 64'h7FFF);
      3'd7:    exp_rd = m_in_d2;
      3'd0:    exp_rd = '0;
      default: exp_rd = m_reg[sel];
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("rd_p1",  bus1.IO_read_data, exp_rd(rsel, 1));
    check("rd_p4",  bus4.IO_read_data, exp_rd(rsel, 4));
    check("c5",     c5_1, m_reg[5]);
    check("c6",     c6_1, m_reg[6]);
    check("c5_p4",  c5_4, m_reg[5]);
    check("c6_p4",  c6_4, m_reg[6]);
    check("pulse",  p_1,  m_pulse);
    check("pulse4", p_4,  m_pulse);
  endtask

  task automatic step(input logic [2:0] rs, input logic we, input logic [2:0] ws,
                      input agc_word_t wd);
    @(negedge clock);
    rsel = rs; wen = we; wsel = ws; wdata = wd;
    #1 check_all();
  endtask

  initial begin
    // Reset held: every select reads zero, writes are ignored.
    wen = 1'b1; wsel = 3'd1; wdata = 15'h1111;
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int s = 0; s < 8; s++) begin
      rsel = 3'(s);
      #1 check("rst_rd", bus1.IO_read_data, 32'h0);
    end
    check("rst_pulse", p_1, 32'h0);
    wen = 1'b0;
    @(negedge clock) reset_n = 1'b1;

    // Scaler after 100 clocks.
    repeat (100) @(posedge clock);
    @(negedge clock);
    rsel = 3'd4;
    #1 check("sc100_lo_p1", bus1.IO_read_data, 32'd100);
    check("sc100_lo_p4", bus4.IO_read_data, 32'd25);
    rsel = 3'd3;
    #1 check("sc100_hi_p1", bus1.IO_read_data, 32'd0);

    // Directed writes: same-cycle read sees the old value.
    step(3'd1, 1'b1, 3'd1, 15'h5A5A);
    check("ch1_same_cycle", bus1.IO_read_data, 32'h0);
    step(3'd1, 1'b1, 3'd6, 15'h7FFF);
    check("ch1_new", bus1.IO_read_data, 32'h5A5A);
    check("pulse_ch1", p_1, 32'h02);
    step(3'd6, 1'b1, 3'd0, 15'h1234);
    check("ch6_new", bus1.IO_read_data, 32'h7FFF);
    check("chan6_out", c6_1, 32'h7FFF);
    step(3'd0, 1'b1, 3'd3, 15'h1234);
    check("ch0_zero", bus1.IO_read_data, 32'h0);
    check("pulse_ch0", p_1, 32'h01);
    step(3'd7, 1'b1, 3'd7, 15'h1234);
    check("pulse_ch3", p_1, 32'h08);
    step(3'd7, 1'b0, 3'd0, 15'h0);
    check("pulse_ch7", p_1, 32'h80);
    check("ch7_unch", bus1.IO_read_data, 32'h0);
    step(3'd7, 1'b0, 3'd0, 15'h0);
    check("pulse_clear", p_1, 32'h0);

    // Asynchronous input change: two edges to reach channel 7.
    @(negedge clock);
    #3 chan_in = 15'h2AAA;
    @(negedge clock);
    #1 check("ch7_one_edge", bus1.IO_read_data, 32'h0);
    @(negedge clock);
    #1 check("ch7_two_edges", bus1.IO_read_data, 32'h2AAA);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 15'($urandom));
      if ($urandom_range(0, 3) == 0) #2 chan_in = 15'($urandom);
    end

    // Mid-operation reset clears immediately.
    @(negedge clock);
    wen = 1'b0;
    #2 reset_n = 1'b0;
    rsel = 3'd4;
    #1 check("midrst_lo_p1", bus1.IO_read_data, 32'h0);
    check("midrst_lo_p4", bus4.IO_read_data, 32'h0);
    check("midrst_c5", c5_1, 32'h0);
    check("midrst_pulse", p_1, 32'h0);
    @(negedge clock) reset_n = 1'b1;

    // Carry from the low half into the high half.
    repeat (32767) @(posedge clock);
    @(negedge clock);
    rsel = 3'd4;
    #1 check("carry_pre_lo", bus1.IO_read_data, 32'h7FFF);
    rsel = 3'd3;
    #1 check("carry_pre_hi", bus1.IO_read_data, 32'h0);
    @(negedge clock);
    rsel = 3'd4;
    #1 check("carry_lo", bus1.IO_read_data, 32'h0);
    check("carry_lo_p4", bus4.IO_read_data, 32'h2000);
    rsel = 3'd3;
    #1 check("carry_hi", bus1.IO_read_data, 32'h1);
    check("carry_hi_p4", bus4.IO_read_data, 32'h0);
    step(3'd3, 1'b0, 3'd0, 15'h0);
    step(3'd4, 1'b0, 3'd0, 15'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
